// File: rtl/mst_wr_rd_arbiter.sv
// Write/read grant arbiter for the AXI4-Lite master issue path.
// Enforces the programmed write:read ratio under contention and keeps wrapping issue counters.
module mst_wr_rd_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       wr_rd_ratio,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_ack,
    output logic             rd_ack,
    output logic             out_valid,
    output logic             out_write,
    input  logic             out_ready,
    output logic [CNT_W-1:0] wr_issued,
    output logic [CNT_W-1:0] rd_issued
);

    localparam logic       STATE_IDLE  = 1'b0;
    localparam logic       STATE_GRANT = 1'b1;
    localparam logic [2:0] RUN_MAX     = 3'd7;

    logic             state_r;
    logic             out_valid_r;
    logic             out_write_r;
    logic             wr_ack_r;
    logic             rd_ack_r;
    logic [2:0]       wr_run_r;
    logic [CNT_W-1:0] wr_issued_r;
    logic [CNT_W-1:0] rd_issued_r;

    logic             ack_cycle_s;
    logic             wr_eff_s;
    logic             rd_eff_s;
    logic             any_req_s;
    logic             pick_write_s;
    logic [2:0]       wr_run_inc_s;

    // Request qualification and write/read decision for the IDLE state.
    always_comb begin
        // The ack cycle is a dead cycle: a requester that releases req after
        // seeing its ack must never be granted a second time.
        ack_cycle_s  = wr_ack_r | rd_ack_r;
        wr_eff_s     = wr_req & ~ack_cycle_s;
        rd_eff_s     = rd_req & ~ack_cycle_s;
        any_req_s    = wr_eff_s | rd_eff_s;
        pick_write_s = 1'b0;
        if (wr_eff_s && rd_eff_s) begin
            pick_write_s = (wr_run_r < wr_rd_ratio);
        end else if (wr_eff_s) begin
            pick_write_s = 1'b1;
        end else begin
            pick_write_s = 1'b0;
        end
        if (wr_run_r == RUN_MAX) begin
            wr_run_inc_s = RUN_MAX;
        end else begin
            wr_run_inc_s = wr_run_r + 3'd1;
        end
    end

    // Grant FSM, handshake acks, run tracking and issue counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= STATE_IDLE;
            out_valid_r <= 1'b0;
            out_write_r <= 1'b0;
            wr_ack_r    <= 1'b0;
            rd_ack_r    <= 1'b0;
            wr_run_r    <= 3'd0;
            wr_issued_r <= {CNT_W{1'b0}};
            rd_issued_r <= {CNT_W{1'b0}};
        end else begin
            wr_ack_r <= 1'b0;
            rd_ack_r <= 1'b0;
            case (state_r)
                STATE_IDLE: begin
                    if (any_req_s) begin
                        out_valid_r <= 1'b1;
                        out_write_r <= pick_write_s;
                        state_r     <= STATE_GRANT;
                    end
                end
                STATE_GRANT: begin
                    // Grant is frozen until accepted; ratio is not resampled here.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= STATE_IDLE;
                        if (out_write_r) begin
                            wr_ack_r    <= 1'b1;
                            wr_issued_r <= wr_issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            wr_run_r    <= wr_run_inc_s;
                        end else begin
                            rd_ack_r    <= 1'b1;
                            rd_issued_r <= rd_issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            wr_run_r    <= 3'd0;
                        end
                    end
                end
                default: begin
                    state_r     <= STATE_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ack    = wr_ack_r;
    assign rd_ack    = rd_ack_r;
    assign out_valid = out_valid_r;
    assign out_write = out_write_r;
    assign wr_issued = wr_issued_r;
    assign rd_issued = rd_issued_r;

endmodule

// File: tb/tb_mst_wr_rd_arbiter.sv
// Directed bench for mst_wr_rd_arbiter: grant-order table plus hold, wrap and reset sequences.
module tb_mst_wr_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  ratio = 3'd0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic        out_ready = 1'b1;

    logic        wr_ack, rd_ack, out_valid, out_write;
    logic [15:0] wr_issued, rd_issued;
    logic        wr_ack4, rd_ack4, out_valid4, out_write4;
    logic [3:0]  wr_issued4, rd_issued4;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    typedef struct packed {
        logic [2:0] ratio;
        logic       wr;
        logic       rd;
        logic [1:0] lat;
        logic       is_write;
    } vec_t;

    vec_t vecs [22];
    int   nvec = 0;

    mst_wr_rd_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .wr_rd_ratio(ratio), .wr_req(wr_req), .rd_req(rd_req),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .out_valid(out_valid), .out_write(out_write),
        .out_ready(out_ready), .wr_issued(wr_issued), .rd_issued(rd_issued)
    );

    mst_wr_rd_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .wr_rd_ratio(ratio), .wr_req(wr_req), .rd_req(rd_req),
        .wr_ack(wr_ack4), .rd_ack(rd_ack4), .out_valid(out_valid4), .out_write(out_write4),
        .out_ready(out_ready), .wr_issued(wr_issued4), .rd_issued(rd_issued4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic w, input logic rd, input logic [1:0] l,
                       input logic iw);
        vecs[nvec] = '{ratio: r, wr: w, rd: rd, lat: l, is_write: iw};
        nvec++;
    endtask

    task automatic check_counts(input string name);
        chk({name, " wr_issued"},  32'(wr_issued),  32'(exp_wr & 16'hFFFF));
        chk({name, " rd_issued"},  32'(rd_issued),  32'(exp_rd & 16'hFFFF));
        chk({name, " wr_issued4"}, 32'(wr_issued4), 32'(exp_wr & 4'hF));
        chk({name, " rd_issued4"}, 32'(rd_issued4), 32'(exp_rd & 4'hF));
    endtask

    // Waits (bounded) for out_valid and checks the edge count it took.
    task automatic wait_valid(input string name, input int exp_lat, input logic exp_write);
        int  lat = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) seen = 1'b1;
        end
        chk({name, " valid"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " out_write"}, 32'(out_write), 32'(exp_write));
        chk({name, " out_write4"}, 32'(out_write4), 32'(exp_write));
    endtask

    task automatic finish_xfer(input string name, input logic exp_write);
        @(posedge clk); #1;
        if (exp_write) exp_wr++; else exp_rd++;
        chk({name, " wr_ack"}, 32'(wr_ack), 32'(exp_write));
        chk({name, " rd_ack"}, 32'(rd_ack), 32'(!exp_write));
        chk({name, " valid drop"}, 32'(out_valid), 32'd0);
        check_counts(name);
    endtask

    initial begin
        // ratio 2, both held: W W R W W R
        add(3'd2, 1'b1, 1'b1, 2'd1, 1'b1);
        add(3'd2, 1'b1, 1'b1, 2'd2, 1'b1);
        add(3'd2, 1'b1, 1'b1, 2'd2, 1'b0);
        add(3'd2, 1'b1, 1'b1, 2'd2, 1'b1);
        add(3'd2, 1'b1, 1'b1, 2'd2, 1'b1);
        add(3'd2, 1'b1, 1'b1, 2'd2, 1'b0);
        // ratio 0: reads always win, then write alone
        add(3'd0, 1'b1, 1'b1, 2'd2, 1'b0);
        add(3'd0, 1'b1, 1'b1, 2'd2, 1'b0);
        add(3'd0, 1'b1, 1'b1, 2'd2, 1'b0);
        add(3'd0, 1'b1, 1'b0, 2'd2, 1'b1);
        // ten uncontended writes saturate the run, first contended grant is a read
        for (int i = 0; i < 10; i++) add(3'd3, 1'b1, 1'b0, 2'd2, 1'b1);
        add(3'd3, 1'b1, 1'b1, 2'd2, 1'b0);
        add(3'd3, 1'b1, 1'b1, 2'd2, 1'b1);

        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_write", 32'(out_write), 32'd0);
        chk("reset wr_ack", 32'(wr_ack), 32'd0);
        chk("reset rd_ack", 32'(rd_ack), 32'd0);
        check_counts("reset");
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle no req", 32'(out_valid), 32'd0);

        for (int i = 0; i < nvec; i++) begin
            ratio  = vecs[i].ratio;
            wr_req = vecs[i].wr;
            rd_req = vecs[i].rd;
            wait_valid($sformatf("vec%0d", i), int'(vecs[i].lat), vecs[i].is_write);
            finish_xfer($sformatf("vec%0d", i), vecs[i].is_write);
        end

        // Write grant held for 5 cycles, ratio dropped 3->0 mid-hold
        out_ready = 1'b0; ratio = 3'd3; wr_req = 1'b1; rd_req = 1'b0;
        wait_valid("hold", 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) ratio = 3'd0;
            chk($sformatf("hold%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d write", i), 32'(out_write), 32'd1);
            chk($sformatf("hold%0d wr_ack", i), 32'(wr_ack), 32'd0);
        end
        out_ready = 1'b1;
        finish_xfer("hold xfer", 1'b1);
        chk("wrap wr_issued4", 32'(wr_issued4), 32'd1);
        rd_req = 1'b1;
        wait_valid("post hold", 2, 1'b0);
        finish_xfer("post hold", 1'b0);

        // Reset asserted mid-GRANT
        out_ready = 1'b0; rd_req = 1'b0; wr_req = 1'b1;
        wait_valid("pre reset", 2, 1'b1);
        #2 rstn = 1'b0;
        #1;
        exp_wr = 0; exp_rd = 0;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst wr_ack", 32'(wr_ack), 32'd0);
        check_counts("async rst");
        out_ready = 1'b1;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        chk("post rst wr_ack", 32'(wr_ack), 32'd0);
        chk("post rst rd_ack", 32'(rd_ack), 32'd0);
        chk("post rst valid", 32'(out_valid), 32'd1);
        chk("post rst write", 32'(out_write), 32'd1);
        finish_xfer("post rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
